// File: rtl/adder16_suite.sv
// Computes a+b+cin three ways (CLA, uniform carry-select, variable carry-select) and registers them.
// Latency is one cycle and there is no backpressure. A registered mismatch flag cross-checks the three results.
module adder16_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_ci,
  output logic [W-1:0] o_s,
  output logic         o_co
);
  always_comb begin
    logic c;
    o_s = '0;
    c   = i_ci;
    for (int i = 0; i < W; i++) begin
      o_s[i] = i_a[i] ^ i_b[i] ^ c;
      c      = (i_a[i] & i_b[i]) | ((i_a[i] ^ i_b[i]) & c);
    end
    o_co = c;
  end
endmodule

// Both legs are always computed; i_sel picks one, so the unused leg never feeds X forward.
module adder16_csel #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sel,
  output logic [W-1:0] o_s,
  output logic         o_co
);
  logic [W-1:0] w_s0, w_s1;
  logic         w_co0, w_co1;

  adder16_rca #(.W(W)) u_leg0 (.i_a(i_a), .i_b(i_b), .i_ci(1'b0), .o_s(w_s0), .o_co(w_co0));
  adder16_rca #(.W(W)) u_leg1 (.i_a(i_a), .i_b(i_b), .i_ci(1'b1), .o_s(w_s1), .o_co(w_co1));

  assign o_s  = i_sel ? w_s1  : w_s0;
  assign o_co = i_sel ? w_co1 : w_co0;
endmodule

module adder16_suite (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum_cla,
  output logic        cout_cla,
  output logic [15:0] sum_csa1,
  output logic        cout_csa1,
  output logic [15:0] sum_csa2,
  output logic        cout_csa2,
  output logic        mismatch
);
  // Expanded 4-way lookahead: returns {c4,c3,c2,c1,c0} from generate/propagate and carry-in.
  function automatic logic [4:0] la4(input logic [3:0] g, input logic [3:0] p, input logic c0);
    logic [4:0] c;
    logic       acc, pp;
    c[0] = c0;
    for (int j = 1; j <= 4; j++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int k = j - 1; k >= 0; k--) begin
        acc = acc | (g[k] & pp);
        pp  = pp & p[k];
      end
      c[j] = acc | (c0 & pp);
    end
    return c;
  endfunction

  logic [15:0] w_p, w_g, w_bc, w_sum_cla;
  logic [3:0]  w_gg, w_gp;
  logic [4:0]  w_gc;
  logic        w_cout_cla;

  assign w_p = a ^ b;
  assign w_g = a & b;

  always_comb begin
    logic [4:0] t;
    w_gg = '0;
    w_gp = '0;
    w_bc = '0;
    for (int i = 0; i < 4; i++) begin
      t       = la4(w_g[4*i +: 4], w_p[4*i +: 4], 1'b0);
      w_gg[i] = t[4];
      w_gp[i] = &w_p[4*i +: 4];
    end
    w_gc = la4(w_gg, w_gp, cin);
    for (int i = 0; i < 4; i++) begin
      t             = la4(w_g[4*i +: 4], w_p[4*i +: 4], w_gc[i]);
      w_bc[4*i +: 4] = t[3:0];
    end
  end

  assign w_sum_cla  = w_p ^ w_bc;
  assign w_cout_cla = w_gc[4];

  // Uniform carry-select: 4 x 4-bit blocks.
  logic [15:0] w_sum_csa1;
  logic [4:0]  w_c1;

  assign w_c1[0] = cin;
  adder16_rca #(.W(4)) u_c1_b0 (.i_a(a[3:0]), .i_b(b[3:0]), .i_ci(w_c1[0]),
                                .o_s(w_sum_csa1[3:0]), .o_co(w_c1[1]));
  for (genvar k = 1; k < 4; k++) begin : g_csa1
    adder16_csel #(.W(4)) u_blk (.i_a(a[4*k +: 4]), .i_b(b[4*k +: 4]), .i_sel(w_c1[k]),
                                 .o_s(w_sum_csa1[4*k +: 4]), .o_co(w_c1[k+1]));
  end

  // Variable carry-select: blocks [1:0], [4:2], [8:5], [15:9].
  logic [15:0] w_sum_csa2;
  logic [3:0]  w_c2;
  logic        w_cout_csa2;

  adder16_rca  #(.W(2)) u_c2_b0 (.i_a(a[1:0]),  .i_b(b[1:0]),  .i_ci(cin),
                                 .o_s(w_sum_csa2[1:0]),  .o_co(w_c2[1]));
  adder16_csel #(.W(3)) u_c2_b1 (.i_a(a[4:2]),  .i_b(b[4:2]),  .i_sel(w_c2[1]),
                                 .o_s(w_sum_csa2[4:2]),  .o_co(w_c2[2]));
  adder16_csel #(.W(4)) u_c2_b2 (.i_a(a[8:5]),  .i_b(b[8:5]),  .i_sel(w_c2[2]),
                                 .o_s(w_sum_csa2[8:5]),  .o_co(w_c2[3]));
  adder16_csel #(.W(7)) u_c2_b3 (.i_a(a[15:9]), .i_b(b[15:9]), .i_sel(w_c2[3]),
                                 .o_s(w_sum_csa2[15:9]), .o_co(w_cout_csa2));
  assign w_c2[0] = cin;

  logic w_mismatch;
  assign w_mismatch = ({w_cout_cla, w_sum_cla} != {w_c1[4], w_sum_csa1}) |
                      ({w_cout_cla, w_sum_cla} != {w_cout_csa2, w_sum_csa2});

  logic [15:0] r_sum_cla, r_sum_csa1, r_sum_csa2;
  logic        r_cout_cla, r_cout_csa1, r_cout_csa2, r_mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_cla   <= '0;
      r_cout_cla  <= 1'b0;
      r_sum_csa1  <= '0;
      r_cout_csa1 <= 1'b0;
      r_sum_csa2  <= '0;
      r_cout_csa2 <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_sum_cla   <= w_sum_cla;
      r_cout_cla  <= w_cout_cla;
      r_sum_csa1  <= w_sum_csa1;
      r_cout_csa1 <= w_c1[4];
      r_sum_csa2  <= w_sum_csa2;
      r_cout_csa2 <= w_cout_csa2;
      r_mismatch  <= w_mismatch;
    end
  end

  assign sum_cla   = r_sum_cla;
  assign cout_cla  = r_cout_cla;
  assign sum_csa1  = r_sum_csa1;
  assign cout_csa1 = r_cout_csa1;
  assign sum_csa2  = r_sum_csa2;
  assign cout_csa2 = r_cout_csa2;
  assign mismatch  = r_mismatch;
endmodule

// File: tb/tb_adder16_suite.sv
// Bench for adder16_suite: directed corner vectors plus random traffic, scoreboarded against a+b+cin one cycle later.
module tb_adder16_suite;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        cin;
  logic [15:0] sum_cla, sum_csa1, sum_csa2;
  logic        cout_cla, cout_csa1, cout_csa2, mismatch;

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] sb_q[$];

  adder16_suite dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum_cla(sum_cla), .cout_cla(cout_cla),
    .sum_csa1(sum_csa1), .cout_csa1(cout_csa1),
    .sum_csa2(sum_csa2), .cout_csa2(cout_csa2),
    .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] golden(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  task automatic check_all(input string tag, input logic [16:0] e);
    chk({tag, "_cla"},  {15'd0, cout_cla,  sum_cla},  {15'd0, e});
    chk({tag, "_csa1"}, {15'd0, cout_csa1, sum_csa1}, {15'd0, e});
    chk({tag, "_csa2"}, {15'd0, cout_csa2, sum_csa2}, {15'd0, e});
    chk({tag, "_mm"},   {31'd0, mismatch}, 32'd0);
  endtask

  task automatic check_pop(input string tag);
    logic [16:0] e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_all(tag, e);
    end
  endtask

  // Compare the result of the previous vector, then drive the next one.
  task automatic apply(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
    @(negedge clk);
    check_pop(tag);
    a   = x;
    b   = y;
    cin = c;
    sb_q.push_back(golden(x, y, c));
  endtask

  // Reset between edges must clear outputs with no clock; the pending result is dropped.
  task automatic pulse_reset();
    @(negedge clk);
    check_pop("pre_rst");
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 17'h0);
    sb_q.delete();
    @(negedge clk);
    check_all("held_rst", 17'h0);
    rst_n = 1'b1;
    sb_q.push_back(golden(a, b, cin));
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 16'h1234;
    b     = 16'h1111;
    cin   = 1'b1;
    repeat (3) @(negedge clk);
    check_all("reset", 17'h0);
    rst_n = 1'b1;
    sb_q.push_back(17'h02346);

    apply("zero",      16'h0000, 16'h0000, 1'b0);
    apply("prop_c0",   16'hAAAA, 16'h5555, 1'b0);
    apply("prop_c1",   16'hAAAA, 16'h5555, 1'b1);
    apply("bnd_7fff",  16'h7FFF, 16'h0001, 1'b0);
    apply("bnd_01ff",  16'h01FF, 16'h0001, 1'b0);
    apply("bnd_001f",  16'h001F, 16'h0001, 1'b0);
    apply("max",       16'hFFFF, 16'hFFFF, 1'b1);
    apply("wrap",      16'hFFFF, 16'h0000, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      if (i == 500) pulse_reset();
      apply("rand", 16'($urandom_range(0, 16'h7FFF)), 16'($urandom_range(0, 16'h7FFF)),
            1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check_pop("drain");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adder16_suite.md
Name: adder16_suite

Overview:
- 16-bit adder comparison block: three independent adder architectures share one operand set.
  - Carry-lookahead adder (CLA).
  - Uniform-block carry-select adder (CSA1).
  - Variable-block carry-select adder (CSA2).
- Each result is registered, and a registered mismatch flag cross-checks the three.
- Used to compare adder structures (timing/area) in the arithmetic datapath; all three results must be bit-identical to a+b+cin.

Parameters:
- None. Operand width is fixed at 16 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- a  input  16  operand A
- b  input  16  operand B
- cin  input  1  carry in
- sum_cla  output  16  registered CLA sum
- cout_cla  output  1  registered CLA carry out
- sum_csa1  output  16  registered uniform carry-select sum
- cout_csa1  output  1  registered uniform carry-select carry out
- sum_csa2  output  16  registered variable carry-select sum
- cout_csa2  output  1  registered variable carry-select carry out
- mismatch  output  1  registered; 1 when the three {cout,sum} results differ

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
  - clk and rst_n as named above.
  - rst_n low forces all outputs to 0 immediately, with no clock needed.
  - Outputs hold 0 while rst_n is low.
  - First capture occurs on the first rising clk edge after rst_n deasserts.
- Arithmetic, per architecture: {cout,sum} = a + b + cin, a 17-bit unsigned result.
  - No overflow flag.
  - Wrap-around is natural modulo 2^16, with carry in cout.
- CLA structure:
  - Four 4-bit lookahead groups, each producing group generate/propagate.
  - A second-level lookahead unit computes carries into bits 4, 8, 12 and cout from cin and the group G/P.
  - Bit-level p = a^b, g = a&b; sum = p ^ c.
- CSA1 structure:
  - Four 4-bit blocks.
  - Block 0 is a plain ripple adder fed by cin.
  - Blocks 1-3 each contain two 4-bit ripple adders, one with carry-in 0 and one with carry-in 1.
  - Sum and carry are selected by a 2:1 mux driven by the previous block's carry-out.
- CSA2 structure:
  - Blocks of 2, 3, 4, 7 bits, LSB first: bits [1:0], [4:2], [8:5], [15:9].
  - Block 0 ripples from cin; the others are duplicated ripple adders with muxed select as in CSA1.
- Latency: exactly 1 cycle. Inputs present before rising edge N appear on the outputs after edge N.
  - No handshake; a new result every cycle.
  - Input changes between edges do not affect outputs until the next edge.
- mismatch:
  - Computed combinationally from the three adder results.
  - Registered on the same edge as the sums, so it aligns with them.
  - Reset value 0.
  - In a correct implementation it never asserts.
- Reset mid-operation: asserting rst_n clears all outputs asynchronously. Any in-flight result is discarded, not replayed.
- No X propagation allowed from the unused mux leg. All internal adders are fully driven.

Test Plan:
- Reset: rst_n=0 with a=16'h1234, b=16'h1111, cin=1 and clock running -> all sums 16'h0000, all couts 0, mismatch 0. Release reset -> next edge gives sums 16'h2346, couts 0.
- Zero: a=0, b=0, cin=0 -> all sums 16'h0000, couts 0, mismatch 0, one cycle after apply.
- Full propagate: a=16'hAAAA, b=16'h5555, cin=0 -> sums 16'hFFFF, couts 0. Then cin=1 -> sums 16'h0000, couts 1 on all three. This exercises the longest carry chain through every select mux and lookahead group.
- Block boundaries: a=16'h7FFF, b=16'h0001, cin=0 -> sums 16'h8000, couts 0. Also a=16'h01FF, b=16'h0001 -> 16'h0200, crossing the CSA2 [8:5]/[15:9] boundary.
- Max operands: a=16'hFFFF, b=16'hFFFF, cin=1 -> sums 16'hFFFF, couts 1.
- Random: 1000 cycles of random 15-bit a, b (bit 15 = 0) and random cin, checked against golden a+b+cin delayed one cycle. mismatch must stay 0 throughout. A rst_n pulse mid-sequence must clear outputs within the same cycle.
